fetch_unit: RTL and testbench

- Instruction-fetch sequencer for the LC3 datapath; the consumer side of the program counter.
- Reads the PC value, issues a memory read at that address and waits on the memory ready handshake.
- Latches the returned word into IR, then commands the PC register to post-increment (ldPC with selPC=00).
- Sits between the control FSM, the PC register and the memory port; replaces the hand-sequenced MAR<-PC, MDR<-M, IR<-MDR control states.

---
 rtl/lc3_pkg.sv | 18 +
 rtl/wait_timer.sv | 33 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC3 datapath encodings
// Fetch FSM states and PC mux selects agreed between the fetch unit and the PC register.
package lc3_pkg;

  localparam int WORD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_EAB = 2'b01;
  localparam logic [1:0] PC_BUS = 2'b10;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - wait-cycle counter for memory handshakes
// expired flags the enabled cycle whose increment brings the count to TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  assign expired = en && !clr && (count_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LC3 instruction fetch sequencer
// Issues PC-addressed reads, loads IR and asks the PC register to post-increment.
module fetch_unit
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            flush,
  input  logic [WORD-1:0] PC,
  input  logic            mem_rdy,
  input  logic [WORD-1:0] mem_rdata,
  output logic [WORD-1:0] mem_addr,
  output logic            mem_rd,
  output logic            ldPC,
  output logic [1:0]      selPC,
  output logic [WORD-1:0] IR,
  output logic            ir_valid,
  output logic            busy,
  output logic            fetch_err
);

  fetch_state_e    state_q, state_d;
  logic [WORD-1:0] mem_addr_q, mem_addr_d;
  logic [WORD-1:0] ir_q, ir_d;
  logic            mem_rd_q, mem_rd_d;
  logic            ldpc_q, ldpc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            busy_q, busy_d;
  logic            fetch_err_q, fetch_err_d;
  logic            tmr_clr, tmr_en, tmr_expired;

  wait_timer #(.TIMEOUT(TIMEOUT), .CW(CW)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    mem_rd_d    = 1'b0;
    ldpc_d      = 1'b0;
    ir_valid_d  = 1'b0;
    fetch_err_d = fetch_err_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          mem_addr_d  = PC;
          fetch_err_d = 1'b0;
          tmr_clr     = 1'b1;
          mem_rd_d    = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          mem_rd_d = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Priority: flush beats mem_rdy, and mem_rdy beats the timeout.
        if (flush) begin
          state_d = IDLE;
        end else if (mem_rdy) begin
          ir_d       = mem_rdata;
          ldpc_d     = 1'b1;
          ir_valid_d = 1'b1;
          state_d    = LOAD;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            fetch_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            mem_rd_d = 1'b1;
          end
        end
      end
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      mem_rd_q    <= 1'b0;
      ldpc_q      <= 1'b0;
      ir_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      mem_rd_q    <= mem_rd_d;
      ldpc_q      <= ldpc_d;
      ir_valid_q  <= ir_valid_d;
      busy_q      <= busy_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign ldPC      = ldpc_q;
  assign selPC     = PC_INC;
  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = busy_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        flush;
  logic [15:0] PC;
  logic        mem_rdy;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        ldPC;
  logic [1:0]  selPC;
  logic [15:0] IR;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;

  fetch_unit #(.TIMEOUT(15), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_req (fetch_req),
    .flush     (flush),
    .PC        (PC),
    .mem_rdy   (mem_rdy),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .ldPC      (ldPC),
    .selPC     (selPC),
    .IR        (IR),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int ldpc_cnt = 0;
  int req_cnt  = 0;
  logic mem_rd_prev = 1'b0;

  // Scoreboard monitor: every ir_valid pulse must match the next expected instruction.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset) begin
      if (ir_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ir_scoreboard unexpected ir_valid IR=%h", IR);
        end else begin
          e = exp_q.pop_front();
          if (IR !== e) begin
            errors++;
            $display("FAIL ir_scoreboard IR=%h expected=%h", IR, e);
          end
        end
      end
      if (ldPC) ldpc_cnt++;
      if (mem_rd && !mem_rd_prev) req_cnt++;
      mem_rd_prev = mem_rd;
    end else begin
      mem_rd_prev = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pulse_fetch();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; fetch_req = 1'b0; flush = 1'b0; PC = 16'h0;
    mem_rdy = 1'b0; mem_rdata = 16'h0;
    tick(); tick();
    chk("reset_mem_rd", {15'b0, mem_rd}, 16'h0);
    chk("reset_IR", IR, 16'h0);
    chk("reset_mem_addr", mem_addr, 16'h0);
    chk("reset_flags", {11'b0, ldPC, ir_valid, busy, fetch_err, 1'b0}, 16'h0);
    chk("reset_selPC", {14'b0, selPC}, 16'h0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic(input logic [15:0] pc, input logic [15:0] data);
    PC = pc; mem_rdata = data; mem_rdy = 1'b1;
    exp_q.push_back(data);
    pulse_fetch();
    chk("basic_c1_mem_rd", {15'b0, mem_rd}, 16'h1);
    chk("basic_c1_addr", mem_addr, pc);
    chk("basic_c1_busy", {15'b0, busy}, 16'h1);
    chk("basic_c1_ldPC", {15'b0, ldPC}, 16'h0);
    tick();
    chk("basic_c2_mem_rd", {15'b0, mem_rd}, 16'h1);
    tick();
    chk("basic_c3_ir_valid", {15'b0, ir_valid}, 16'h1);
    chk("basic_c3_ldPC", {15'b0, ldPC}, 16'h1);
    chk("basic_c3_mem_rd", {15'b0, mem_rd}, 16'h0);
    chk("basic_c3_selPC", {14'b0, selPC}, 16'h0);
    chk("basic_c3_IR", IR, data);
    mem_rdy = 1'b0;
    tick();
    chk("basic_c4_busy", {15'b0, busy}, 16'h0);
    chk("basic_c4_pulse", {14'b0, ldPC, ir_valid}, 16'h0);
  endtask

  task automatic test_wait_states();
    int ld0;
    ld0 = ldpc_cnt;
    PC = 16'h3001; mem_rdata = 16'hABCD; mem_rdy = 1'b0;
    exp_q.push_back(16'hABCD);
    pulse_fetch();
    for (int i = 0; i < 6; i++) begin
      chk("wait_mem_rd_held", {15'b0, mem_rd}, 16'h1);
      chk("wait_addr_stable", mem_addr, 16'h3001);
      PC = 16'($urandom);
      if (i == 5) mem_rdy = 1'b1;
      tick();
    end
    chk("wait_load_ir_valid", {15'b0, ir_valid}, 16'h1);
    chk("wait_load_mem_rd", {15'b0, mem_rd}, 16'h0);
    chk("wait_IR", IR, 16'hABCD);
    mem_rdy = 1'b0;
    tick(); #2;
    chk("wait_ldPC_once", 16'(ldpc_cnt - ld0), 16'h1);
  endtask

  task automatic test_timeout();
    int ld0;
    ld0 = ldpc_cnt;
    mem_rdy = 1'b0; PC = 16'h3100;
    pulse_fetch();
    tick();
    for (int i = 1; i < 15; i++) begin
      chk("timeout_early_err", {14'b0, mem_rd, fetch_err}, 16'h2);
      tick();
    end
    chk("timeout_wait15_mem_rd", {15'b0, mem_rd}, 16'h1);
    tick();
    chk("timeout_fetch_err", {15'b0, fetch_err}, 16'h1);
    chk("timeout_mem_rd", {15'b0, mem_rd}, 16'h0);
    chk("timeout_busy", {15'b0, busy}, 16'h0);
    chk("timeout_IR_kept", IR, 16'hABCD);
    #2;
    chk("timeout_no_ldPC", 16'(ldpc_cnt - ld0), 16'h0);
    tick();
    chk("timeout_err_sticky", {15'b0, fetch_err}, 16'h1);
    PC = 16'h4000; mem_rdata = 16'h5555; mem_rdy = 1'b1;
    exp_q.push_back(16'h5555);
    pulse_fetch();
    chk("timeout_err_cleared", {15'b0, fetch_err}, 16'h0);
    tick(); tick();
    mem_rdy = 1'b0;
    tick();
  endtask

  task automatic test_rdy_at_timeout();
    PC = 16'h4100; mem_rdata = 16'h7777; mem_rdy = 1'b0;
    exp_q.push_back(16'h7777);
    pulse_fetch();
    tick();
    for (int i = 1; i < 15; i++) tick();
    mem_rdy = 1'b1;
    tick();
    chk("rdy_wins_ir_valid", {15'b0, ir_valid}, 16'h1);
    chk("rdy_wins_no_err", {15'b0, fetch_err}, 16'h0);
    mem_rdy = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int ld0;
    ld0 = ldpc_cnt;
    PC = 16'h5000; mem_rdata = 16'hBEEF; mem_rdy = 1'b1;
    pulse_fetch();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; mem_rdy = 1'b0;
    chk("flush_busy", {15'b0, busy}, 16'h0);
    chk("flush_mem_rd", {15'b0, mem_rd}, 16'h0);
    chk("flush_pulses", {14'b0, ldPC, ir_valid}, 16'h0);
    chk("flush_IR_kept", IR, 16'h7777);
    chk("flush_err_kept", {15'b0, fetch_err}, 16'h0);
    tick(); #2;
    chk("flush_no_ldPC", 16'(ldpc_cnt - ld0), 16'h0);
  endtask

  task automatic test_back_to_back();
    int r0, ld0;
    r0 = req_cnt; ld0 = ldpc_cnt;
    PC = 16'hFFFF; mem_rdata = 16'h0F0F; mem_rdy = 1'b0;
    exp_q.push_back(16'h0F0F);
    pulse_fetch();
    fetch_req = 1'b1;
    PC = 16'h1111;
    tick();
    mem_rdy = 1'b1;
    tick();
    fetch_req = 1'b0; mem_rdy = 1'b0;
    chk("wrap_addr", mem_addr, 16'hFFFF);
    chk("wrap_ldPC", {15'b0, ldPC}, 16'h1);
    tick();
    chk("wrap_idle", {14'b0, busy, mem_rd}, 16'h0);
    tick(); #2;
    chk("busy_req_ignored", 16'(req_cnt - r0), 16'h1);
    chk("wrap_ldPC_once", 16'(ldpc_cnt - ld0), 16'h1);
  endtask

  task automatic test_async_reset();
    PC = 16'h6000; mem_rdy = 1'b0;
    pulse_fetch();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_mem_rd", {15'b0, mem_rd}, 16'h0);
    chk("async_busy_ldPC", {14'b0, busy, ldPC}, 16'h0);
    chk("async_IR", IR, 16'h0);
    tick();
    reset = 1'b1;
    tick();
    test_basic(16'h3000, 16'h1234);
  endtask

  initial begin
    test_reset();
    test_basic(16'h3000, 16'h1234);
    test_wait_states();
    test_timeout();
    test_rdy_at_timeout();
    test_flush();
    test_back_to_back();
    test_async_reset();
    tick();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
